ppe_stm_mem_rd: RTL and testbench

Read-side client for the PPE STM memory. Accepts tagged lookup requests over a valid/ready interface, drives the STM SRAM read port, and tracks each read through the fixed memory latency. Read data and error status land in a credit-protected response FIFO, so in-order responses never drop under downstream backpressure. Sits between the PPE lookup pipeline and the STM memory instance.

---
 rtl/ppe_stm_mem_rd.sv | 142 ++++++++++++++
 tb/tb_ppe_stm_mem_rd.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppe_stm_mem_rd.sv
// ppe_stm_mem_rd: read-side STM client. Takes tagged lookups, issues SRAM
// reads, follows each read through the fixed memory latency and buffers the
// returned data in a credit-protected in-order response FIFO.
module ppe_stm_mem_rd #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned DEPTH   = 8
) (
    input  logic              cclk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_adr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_err,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic [15:0]       err_cnt,
    output logic              busy
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned STAGES = MEM_LAT + 1;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  fcnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [STAGES-1:0] stg_vld;
    logic [TAG_W-1:0]  stg_tag [STAGES];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [TAG_W-1:0]  fifo_tag  [DEPTH];
    logic              fifo_err  [DEPTH];

    logic accept;
    logic pop;
    logic fifo_wr;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decodes; ready and busy come from the registered credit count only
    assign req_ready = (cnt != CNT_W'(DEPTH));
    assign busy      = (cnt != '0);
    assign accept    = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;
    assign fifo_wr   = stg_vld[STAGES-1];

    // Response head: driven straight from the head entry registers
    assign rsp_valid = (fcnt != '0);
    assign rsp_data  = fifo_data[rd_ptr];
    assign rsp_tag   = fifo_tag[rd_ptr];
    assign rsp_err   = fifo_err[rd_ptr];

    // Credit counter: in-flight plus buffered entries
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    // SRAM read port, address holds between reads
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            mem_rd_en  <= 1'b0;
            mem_rd_adr <= '0;
        end else begin
            mem_rd_en <= accept;
            if (accept) begin
                mem_rd_adr <= req_addr;
            end
        end
    end

    // Tag pipeline; last stage lines up with mem_rd_data, reset drops in-flight reads
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            stg_vld <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                stg_tag[i] <= '0;
            end
        end else begin
            stg_vld    <= {stg_vld[STAGES-2:0], accept};
            stg_tag[0] <= req_tag;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stg_tag[i] <= stg_tag[i-1];
            end
        end
    end

    // Response FIFO storage and pointers
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_tag[i]  <= '0;
                fifo_err[i]  <= 1'b0;
            end
        end else begin
            if (fifo_wr) begin
                fifo_data[wr_ptr] <= mem_rd_data;
                fifo_tag[wr_ptr]  <= stg_tag[STAGES-1];
                fifo_err[wr_ptr]  <= mem_rd_err;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fcnt <= fcnt + CNT_W'(fifo_wr) - CNT_W'(pop);
        end
    end

    // Saturating count of error responses written
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (fifo_wr && mem_rd_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    // Credits bound the FIFO occupancy, so a write never finds it full
    a_no_overflow: assert property (@(posedge cclk) disable iff (rst)
        fifo_wr |-> (fcnt != CNT_W'(DEPTH)));

endmodule

// File: tb/tb_ppe_stm_mem_rd.sv
// Bench for ppe_stm_mem_rd: SRAM model, queue-based response model checked
// every cycle, directed scenarios with literal expectations, plus a
// MEM_LAT=1 / DEPTH=1 instance for the one-outstanding corner.
module tb_ppe_stm_mem_rd;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned DEPTH   = 8;

    logic              cclk = 1'b0;
    logic              rst  = 1'b1;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [TAG_W-1:0]  req_tag;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_adr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_err;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;
    logic [15:0]       err_cnt;
    logic              busy;

    logic              req_valid1, req_ready1;
    logic [ADDR_W-1:0] req_addr1;
    logic [TAG_W-1:0]  req_tag1;
    logic              mem_rd_en1;
    logic [ADDR_W-1:0] mem_rd_adr1;
    logic [DATA_W-1:0] mem_rd_data1;
    logic              mem_rd_err1;
    logic              rsp_valid1, rsp_ready1;
    logic [DATA_W-1:0] rsp_data1;
    logic [TAG_W-1:0]  rsp_tag1;
    logic              rsp_err1;
    logic [15:0]       err_cnt1;
    logic              busy1;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] sram_data [1024];
    logic              sram_err  [1024];

    always #5 cclk = ~cclk;

    ppe_stm_mem_rd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                     .MEM_LAT(MEM_LAT), .DEPTH(DEPTH)) dut (
        .cclk(cclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
        .mem_rd_en(mem_rd_en), .mem_rd_adr(mem_rd_adr),
        .mem_rd_data(mem_rd_data), .mem_rd_err(mem_rd_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .err_cnt(err_cnt), .busy(busy)
    );

    ppe_stm_mem_rd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                     .MEM_LAT(1), .DEPTH(1)) dut1 (
        .cclk(cclk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1), .req_tag(req_tag1),
        .mem_rd_en(mem_rd_en1), .mem_rd_adr(mem_rd_adr1),
        .mem_rd_data(mem_rd_data1), .mem_rd_err(mem_rd_err1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .rsp_tag(rsp_tag1), .rsp_err(rsp_err1), .err_cnt(err_cnt1), .busy(busy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM model: data appears MEM_LAT cycles after the enable, garbage otherwise
    logic [DATA_W-1:0] rd_pipe  [MEM_LAT];
    logic              err_pipe [MEM_LAT];
    always @(posedge cclk) begin
        rd_pipe[0]  <= mem_rd_en ? sram_data[mem_rd_adr] : {DATA_W{1'b1}};
        err_pipe[0] <= mem_rd_en ? sram_err[mem_rd_adr] : 1'b1;
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_pipe[i]  <= rd_pipe[i-1];
            err_pipe[i] <= err_pipe[i-1];
        end
    end
    assign mem_rd_data = rd_pipe[MEM_LAT-1];
    assign mem_rd_err  = err_pipe[MEM_LAT-1];

    // Single-cycle SRAM for the corner instance
    always @(posedge cclk) begin
        mem_rd_data1 <= mem_rd_en1 ? sram_data[mem_rd_adr1] : {DATA_W{1'b1}};
        mem_rd_err1  <= mem_rd_en1 ? sram_err[mem_rd_adr1] : 1'b1;
    end

    // Observed DUT handshakes
    int dut_pops = 0, dut_acc = 0, dut_errpops = 0;
    always @(negedge cclk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) dut_pops++;
            if (rsp_valid && rsp_ready && rsp_err) dut_errpops++;
            if (req_valid && req_ready) dut_acc++;
        end
    end

    // Transaction model: each accepted request becomes visible MEM_LAT+2 cycles later
    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              err;
        int                rdy;
    } ent_t;
    ent_t              mq[$];
    int                cyc = 0;
    int                sat_seq = 0, sat_seen = 0;
    logic              exp_en = 1'b0;
    logic [ADDR_W-1:0] exp_adr = '0;
    logic [15:0]       exp_ec = '0;

    always @(negedge cclk) begin
        logic exp_ready, exp_rv;
        cyc++;
        if (sat_seq != sat_seen) begin
            exp_ec   = 16'hFFFE;
            sat_seen = sat_seq;
        end
        if (rst) begin
            check("rst_req_ready", 64'(req_ready), 1);
            check("rst_mem_rd_en", 64'(mem_rd_en), 0);
            check("rst_mem_rd_adr", 64'(mem_rd_adr), 0);
            check("rst_rsp_valid", 64'(rsp_valid), 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_rsp_tag", 64'(rsp_tag), 0);
            check("rst_rsp_err", 64'(rsp_err), 0);
            check("rst_err_cnt", 64'(err_cnt), 0);
            check("rst_busy", 64'(busy), 0);
            mq.delete();
            exp_en  = 1'b0;
            exp_adr = '0;
            exp_ec  = '0;
        end else begin
            foreach (mq[i]) begin
                if (mq[i].rdy == cyc && mq[i].err && exp_ec != 16'hFFFF) exp_ec++;
            end
            exp_ready = (mq.size() < DEPTH);
            exp_rv    = (mq.size() > 0) && (mq[0].rdy <= cyc);
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("busy", 64'(busy), 64'(mq.size() != 0));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("mem_rd_en", 64'(mem_rd_en), 64'(exp_en));
            check("mem_rd_adr", 64'(mem_rd_adr), 64'(exp_adr));
            check("err_cnt", 64'(err_cnt), 64'(exp_ec));
            if (exp_rv) begin
                check("rsp_data", rsp_data, mq[0].data);
                check("rsp_tag", 64'(rsp_tag), 64'(mq[0].tag));
                check("rsp_err", 64'(rsp_err), 64'(mq[0].err));
            end
            exp_en = 1'b0;
            if (exp_rv && rsp_ready) void'(mq.pop_front());
            if (req_valid && exp_ready) begin
                mq.push_back('{req_tag, sram_data[req_addr], sram_err[req_addr], cyc + MEM_LAT + 2});
                exp_en  = 1'b1;
                exp_adr = req_addr;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge cclk);
            #1;
        end
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic send(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_tag   = t;
        repeat (50) begin
            @(negedge cclk);
            ok = req_ready;
            @(posedge cclk);
            #1;
            if (ok) break;
        end
        req_valid = 1'b0;
        if (!ok) check("send_timeout", 64'(ok), 1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        repeat (200) begin
            @(negedge cclk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge cclk);
        #1;
        if (!done) check("idle_timeout", 64'(done), 1);
    endtask

    initial begin
        int p0, a0, e0, stall;
        logic [7:0] exp_r1, exp_v1;

        for (int i = 0; i < 1024; i++) begin
            sram_data[i] = {32'hA5C3_0000 | 32'(i), ~32'(i * 977)};
            sram_err[i]  = 1'b0;
        end
        sram_data[10'h155] = 64'hDEADBEEF_00000001;
        sram_err[10'h021]  = 1'b1;
        sram_err[10'h024]  = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_tag = '0; rsp_ready = 1'b1;
        req_valid1 = 1'b0; req_addr1 = '0; req_tag1 = '0; rsp_ready1 = 1'b1;

        step(3);
        rst = 1'b0;
        step(5);
        check("init_req_ready", 64'(req_ready), 1);
        check("init_err_cnt", 64'(err_cnt), 0);

        // Single read: issue next cycle, response MEM_LAT+2 after accept
        send(10'h155, 4'd3);
        @(negedge cclk);
        check("single_en", 64'(mem_rd_en), 1);
        check("single_adr", 64'(mem_rd_adr), 64'h155);
        repeat (MEM_LAT) @(negedge cclk);
        check("single_early", 64'(rsp_valid), 0);
        @(negedge cclk);
        check("single_valid", 64'(rsp_valid), 1);
        check("single_data", rsp_data, 64'hDEADBEEF_00000001);
        check("single_tag", 64'(rsp_tag), 3);
        check("single_err", 64'(rsp_err), 0);
        wait_idle();

        // Streaming: 32 back-to-back with tags wrapping
        p0 = dut_pops;
        stall = 0;
        for (int i = 0; i < 32; i++) begin
            req_valid = 1'b1;
            req_addr  = ADDR_W'(10'h040 + i * 3);
            req_tag   = TAG_W'(i);
            @(negedge cclk);
            if (!req_ready) stall++;
            @(posedge cclk);
            #1;
        end
        req_valid = 1'b0;
        wait_idle();
        check("stream_stalls", 64'(stall), 0);
        check("stream_count", 64'(dut_pops - p0), 32);

        // Backpressure: exactly DEPTH accepted, credit returns after first pop
        rsp_ready = 1'b0;
        a0 = dut_acc;
        p0 = dut_pops;
        req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_addr = ADDR_W'(10'h080 + (dut_acc - a0));
            req_tag  = TAG_W'(dut_acc - a0);
            step(1);
        end
        req_valid = 1'b0;
        check("bp_accepts", 64'(dut_acc - a0), 8);
        @(negedge cclk);
        check("bp_full_ready", 64'(req_ready), 0);
        step(1);
        rsp_ready = 1'b1;
        @(negedge cclk);
        check("bp_pop_valid", 64'(rsp_valid), 1);
        check("bp_pop_ready", 64'(req_ready), 0);
        @(negedge cclk);
        check("bp_credit_back", 64'(req_ready), 1);
        wait_idle();
        check("bp_count", 64'(dut_pops - p0), 8);

        // ECC: errors on responses 2 and 5 of 6
        e0 = dut_errpops;
        for (int i = 0; i < 6; i++) send(ADDR_W'(10'h020 + i), TAG_W'(i));
        wait_idle();
        check("ecc_err_cnt", 64'(err_cnt), 2);
        check("ecc_err_rsps", 64'(dut_errpops - e0), 2);

        // Saturation
        force dut.err_cnt = 16'hFFFE;
        sat_seq++;
        step(1);
        release dut.err_cnt;
        send(10'h021, 4'd9);
        wait_idle();
        check("sat_reach", 64'(err_cnt), 64'hFFFF);
        send(10'h024, 4'd10);
        wait_idle();
        check("sat_hold", 64'(err_cnt), 64'hFFFF);

        // Reset with 2 buffered and 3 in flight
        rsp_ready = 1'b0;
        send(10'h030, 4'd1);
        send(10'h031, 4'd2);
        step(MEM_LAT + 3);
        send(10'h032, 4'd3);
        send(10'h033, 4'd4);
        send(10'h034, 4'd5);
        rst = 1'b1;
        @(negedge cclk);
        check("mid_rst_valid", 64'(rsp_valid), 0);
        check("mid_rst_err_cnt", 64'(err_cnt), 0);
        check("mid_rst_ready", 64'(req_ready), 1);
        check("mid_rst_busy", 64'(busy), 0);
        step(2);
        rst = 1'b0;
        rsp_ready = 1'b1;
        p0 = dut_pops;
        step(8);
        check("post_rst_no_rsp", 64'(dut_pops - p0), 0);
        send(10'h155, 4'd7);
        wait_idle();
        check("post_rst_rsp", 64'(dut_pops - p0), 1);

        // MEM_LAT=1, DEPTH=1: one outstanding, ready returns the cycle after pop
        exp_r1 = 8'b0001_0001;
        exp_v1 = 8'b1000_1000;
        req_valid1 = 1'b1;
        req_addr1  = 10'h003;
        req_tag1   = 4'd1;
        for (int k = 0; k < 8; k++) begin
            @(negedge cclk);
            check($sformatf("c1_ready_%0d", k), 64'(req_ready1), 64'(exp_r1[k]));
            check($sformatf("c1_valid_%0d", k), 64'(rsp_valid1), 64'(exp_v1[k]));
            if (exp_v1[k]) begin
                check($sformatf("c1_data_%0d", k), rsp_data1, (k == 3) ? sram_data[3] : sram_data[4]);
                check($sformatf("c1_tag_%0d", k), 64'(rsp_tag1), (k == 3) ? 64'd1 : 64'd2);
            end
            step(1);
            if (k == 0) begin
                req_addr1 = 10'h004;
                req_tag1  = 4'd2;
            end
            if (k == 4) req_valid1 = 1'b0;
        end
        step(2);
        check("c1_idle", 64'(busy1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
